// File: rtl/timer_sequencer_pkg.sv
// timer_seq_pkg: shared state encoding, mode encodings and default widths for the timer sequencer
package timer_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_PRESCALE_W = 4;

endpackage

// File: rtl/timer_sequencer_count_core.sv
// count_core: WIDTH-bit up counter with synchronous clear that overrides enable
module count_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    // clear wins over increment; wraps modulo 2^WIDTH
    always_ff @(posedge clk) begin
        if (reset)   q <= '0;
        else if (clr) q <= '0;
        else if (en)  q <= q + 1'b1;
    end

endmodule

// File: rtl/timer_sequencer.sv
// timer_sequencer: prescaled one-shot/periodic timer FSM with registered status outputs
module timer_sequencer
    import timer_seq_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  mode,
    input  logic [WIDTH-1:0]      load_val,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      o_count,
    output logic                  busy,
    output logic                  done,
    output logic                  tick
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [WIDTH-1:0]      r_term;
    logic [PRESCALE_W-1:0] r_p;
    logic [PRESCALE_W-1:0] r_presc;
    logic                  r_mode;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_tick;
    logic                  w_start_acc;
    logic                  w_count_en;
    logic                  w_term;
    logic                  w_clr;
    logic                  w_en;
    logic                  w_busy_nxt;
    logic                  w_done_nxt;
    logic                  w_tick_nxt;

    assign w_start_acc = start & ~stop;
    assign w_count_en  = (r_state == RUN) && (r_presc == r_p);
    assign w_term      = w_count_en && (o_count == r_term);
    assign w_clr       = w_start_acc | (w_term & ~stop);
    assign w_en        = w_count_en & ~stop & ~w_term;

    count_core #(.WIDTH(WIDTH)) u_count (
        .clk   (clk),
        .reset (reset),
        .clr   (w_clr),
        .en    (w_en),
        .q     (o_count)
    );

    // state and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_tick  <= w_tick_nxt;
        end
    end

    // stop beats start, start beats the terminal event, terminal picks RUN or DONE by mode
    always_comb begin
        w_state_nxt = stop        ? IDLE :
                      w_start_acc ? RUN  :
                      w_term      ? ((r_mode == MODE_PERIODIC) ? RUN : DONE) :
                      r_state;
    end

    // status outputs precomputed from the next state so they come straight off flops
    always_comb begin
        w_busy_nxt = (w_state_nxt == RUN);
        w_done_nxt = (w_state_nxt == DONE);
        w_tick_nxt = w_term & ~stop;
    end

    // run parameters latched on an accepted start; prescaler wraps at p_q while running
    always_ff @(posedge clk) begin
        if (reset) begin
            r_term  <= '0;
            r_p     <= '0;
            r_mode  <= MODE_ONESHOT;
            r_presc <= '0;
        end else begin
            if (w_start_acc) begin
                r_term <= load_val;
                r_p    <= prescale;
                r_mode <= mode;
            end
            if (stop || w_start_acc || r_state != RUN) r_presc <= '0;
            else                                        r_presc <= (r_presc == r_p) ? '0 : r_presc + 1'b1;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign tick = r_tick;

endmodule

// File: tb/tb_timer_sequencer.sv
// tb_timer_sequencer: directed self-checking bench for timer_sequencer
module tb_timer_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       stop;
    logic       mode;
    logic [7:0] load_val;
    logic [3:0] prescale;
    logic [7:0] o_count;
    logic       busy;
    logic       done;
    logic       tick;

    int n_tests = 0;
    int n_fail  = 0;

    timer_sequencer #(.WIDTH(8), .PRESCALE_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .mode     (mode),
        .load_val (load_val),
        .prescale (prescale),
        .o_count  (o_count),
        .busy     (busy),
        .done     (done),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // pulse start for one edge (edge 0 of the run)
    task automatic launch(input logic m, input logic [7:0] lv, input logic [3:0] p);
        mode = m; load_val = lv; prescale = p; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; stop = 1'b0; mode = 1'b1; load_val = 8'd9; prescale = 4'd2;
        step();
        step();
        n_tests++;
        if ({o_count, busy, done, tick} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got count=%0d busy=%0b done=%0b tick=%0b want all 0", o_count, busy, done, tick);
        end
        reset = 1'b0; start = 1'b0;
        step();
        n_tests++;
        if (busy !== 1'b0 || o_count !== 8'd0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%0b count=%0d want 0/0", busy, o_count);
        end
    endtask

    task automatic test_oneshot();
        launch(1'b0, 8'd3, 4'd0);
        load_val = 8'd0; prescale = 4'd7; mode = 1'b1;
        n_tests++;
        if (busy !== 1'b1 || o_count !== 8'd0) begin
            n_fail++;
            $display("FAIL oneshot_start: got busy=%0b count=%0d want 1/0", busy, o_count);
        end
        for (int k = 1; k <= 3; k++) begin
            step();
            n_tests++;
            if (o_count !== 8'(k) || tick !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL oneshot_step%0d: got count=%0d tick=%0b busy=%0b want %0d/0/1", k, o_count, tick, busy, k);
            end
        end
        step();
        n_tests++;
        if (tick !== 1'b1 || o_count !== 8'd0 || done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL oneshot_terminal: got tick=%0b count=%0d done=%0b busy=%0b want 1/0/1/0", tick, o_count, done, busy);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            n_tests++;
            if (tick !== 1'b0 || o_count !== 8'd0 || done !== 1'b1) begin
                n_fail++;
                $display("FAIL oneshot_done_hold: got tick=%0b count=%0d done=%0b want 0/0/1", tick, o_count, done);
            end
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_stop: got done=%0b busy=%0b want 0/0", done, busy);
        end
    endtask

    task automatic test_periodic();
        launch(1'b1, 8'd2, 4'd1);
        for (int k = 1; k <= 19; k++) begin
            step();
            n_tests++;
            if (tick !== (k % 6 == 0) || busy !== 1'b1 || o_count !== 8'((k / 2) % 3) || done !== 1'b0) begin
                n_fail++;
                $display("FAIL periodic_cycle%0d: got tick=%0b busy=%0b count=%0d want %0b/1/%0d", k, tick, busy, o_count, (k % 6 == 0), (k / 2) % 3);
            end
        end
        step();
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || tick !== 1'b0 || o_count !== 8'd1) begin
            n_fail++;
            $display("FAIL periodic_stop: got busy=%0b tick=%0b count=%0d want 0/0/1", busy, tick, o_count);
        end
    endtask

    task automatic test_stop_terminal();
        launch(1'b0, 8'd1, 4'd0);
        step();
        n_tests++;
        if (o_count !== 8'd1) begin
            n_fail++;
            $display("FAIL stopterm_pre: got count=%0d want 1", o_count);
        end
        stop = 1'b1; start = 1'b1;
        step();
        stop = 1'b0; start = 1'b0;
        n_tests++;
        if (tick !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || o_count !== 8'd1) begin
            n_fail++;
            $display("FAIL stopterm: got tick=%0b busy=%0b done=%0b count=%0d want 0/0/0/1", tick, busy, done, o_count);
        end
        step();
        step();
        n_tests++;
        if (o_count !== 8'd1 || tick !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_hold: got count=%0d tick=%0b busy=%0b want 1/0/0", o_count, tick, busy);
        end
    endtask

    task automatic test_restart();
        launch(1'b0, 8'd5, 4'd0);
        step();
        step();
        n_tests++;
        if (o_count !== 8'd2) begin
            n_fail++;
            $display("FAIL restart_pre: got count=%0d want 2", o_count);
        end
        launch(1'b0, 8'd1, 4'd0);
        n_tests++;
        if (o_count !== 8'd0 || busy !== 1'b1 || tick !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_clear: got count=%0d busy=%0b tick=%0b want 0/1/0", o_count, busy, tick);
        end
        step();
        n_tests++;
        if (o_count !== 8'd1 || tick !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_cycle4: got count=%0d tick=%0b want 1/0", o_count, tick);
        end
        step();
        n_tests++;
        if (tick !== 1'b1 || o_count !== 8'd0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_tick: got tick=%0b count=%0d done=%0b want 1/0/1", tick, o_count, done);
        end
    endtask

    task automatic test_reset_midrun();
        int ticks;
        launch(1'b1, 8'd255, 4'd15);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_tests++;
        if ({o_count, busy, done, tick} !== 11'd0) begin
            n_fail++;
            $display("FAIL midrun_reset: got count=%0d busy=%0b done=%0b tick=%0b want all 0", o_count, busy, done, tick);
        end
        ticks = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            ticks += int'(tick) + int'(busy);
        end
        n_tests++;
        if (ticks !== 0) begin
            n_fail++;
            $display("FAIL post_reset_quiet: got %0d tick/busy cycles want 0", ticks);
        end
        launch(1'b0, 8'd0, 4'd0);
        step();
        n_tests++;
        if (tick !== 1'b1 || done !== 1'b1 || o_count !== 8'd0) begin
            n_fail++;
            $display("FAIL term_zero: got tick=%0b done=%0b count=%0d want 1/1/0", tick, done, o_count);
        end
    endtask

    task automatic test_full_range();
        int early;
        launch(1'b0, 8'd255, 4'd0);
        early = 0;
        for (int k = 1; k <= 255; k++) begin
            step();
            early += int'(tick);
        end
        n_tests++;
        if (o_count !== 8'd255 || early !== 0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL full_pre: got count=%0d early_ticks=%0d busy=%0b want 255/0/1", o_count, early, busy);
        end
        step();
        n_tests++;
        if (tick !== 1'b1 || o_count !== 8'd0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL full_tick: got tick=%0b count=%0d done=%0b want 1/0/1", tick, o_count, done);
        end
    endtask

    task automatic test_prescale();
        launch(1'b0, 8'd1, 4'd3);
        for (int k = 1; k <= 8; k++) begin
            step();
            n_tests++;
            if (tick !== (k == 8) || o_count !== ((k >= 4 && k < 8) ? 8'd1 : 8'd0)) begin
                n_fail++;
                $display("FAIL prescale_cycle%0d: got tick=%0b count=%0d", k, tick, o_count);
            end
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_stop_terminal();
        test_restart();
        test_reset_midrun();
        test_full_range();
        test_prescale();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_sequencer.md
TIMER_SEQUENCER -- requirements
Module: timer_sequencer

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, setting the count and terminal-value width.
REQ-002 The module SHALL have parameter PRESCALE_W, default 4, setting the prescaler width.
REQ-003 The module SHALL use one clock, clk, and one reset, reset; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  single-cycle request to begin a timing run.
REQ-007 stop  input  1  abort request.
REQ-008 mode  input  1  0 = one-shot, 1 = periodic; sampled on an accepted start.
REQ-009 load_val  input  WIDTH  terminal count; sampled on an accepted start.
REQ-010 prescale  input  PRESCALE_W  divider P, giving one count step every P+1 clocks; sampled on an accepted start.
REQ-011 o_count  output  WIDTH  current count value.
REQ-012 busy  output  1  high while in state RUN.
REQ-013 done  output  1  high while in state DONE.
REQ-014 tick  output  1  registered single-cycle pulse at each terminal event.

Function
REQ-015 The FSM SHALL have three states, IDLE, RUN and DONE, and SHALL drive all outputs from registers.
REQ-016 In IDLE with start=1 and stop=0, the block SHALL:
- latch load_val, prescale and mode into term_q, p_q and mode_q;
- clear o_count and the prescaler;
- enter RUN.
REQ-017 In RUN, the prescaler SHALL count 0..p_q; count_en SHALL be high in each cycle where prescaler==p_q, and the prescaler SHALL then wrap to 0.
REQ-018 On an edge with count_en=1 and o_count!=term_q, o_count SHALL increment by 1.
REQ-019 On an edge with count_en=1 and o_count==term_q (terminal event), the block SHALL:
- set o_count to 0;
- pulse tick for exactly one cycle;
- remain in RUN if mode_q=1, else enter DONE.
REQ-020 The first tick after an accepted start SHALL be high exactly (term_q+1)*(p_q+1) clocks after the start edge; in periodic mode, subsequent ticks SHALL repeat at that same interval.
REQ-021 With term_q=0, a terminal event SHALL occur on every count_en; with p_q=0, count_en SHALL be high on every RUN cycle.
REQ-022 stop=1 in RUN or DONE SHALL move the FSM to IDLE on that edge, with o_count frozen, no tick and the prescaler cleared.
REQ-023 stop SHALL take priority over start and over a coincident terminal event; the terminal event SHALL then be suppressed.
REQ-024 start=1 with stop=0 in RUN or DONE SHALL restart the run: relatch per REQ-016, clear o_count and the prescaler, and be in RUN.
REQ-025 In DONE without start or stop, o_count SHALL stay 0, done SHALL stay 1, and tick SHALL stay 0.
REQ-026 In IDLE, o_count SHALL hold its value and count_en SHALL be 0.
REQ-027 Count arithmetic SHALL be unsigned modulo 2^WIDTH; term_q = 2^WIDTH-1 SHALL be a valid full-range terminal.
REQ-028 Changes on mode, load_val or prescale SHALL have no effect on the current run until the next accepted start.

Reset
REQ-029 reset=1 SHALL, on the next clk edge, apply the following regardless of state or other inputs:
- state = IDLE;
- o_count, term_q, p_q, mode_q and the prescaler = 0;
- busy, done and tick = 0.
REQ-030 Reset asserted mid-run SHALL abort the run with no tick; the first start after reset deassertion SHALL behave per REQ-016.

Structure
REQ-031 A shared package timer_seq_pkg SHALL hold:
- the state enumeration IDLE/RUN/DONE;
- the mode encodings MODE_ONESHOT=0 and MODE_PERIODIC=1;
- the default WIDTH and PRESCALE_W constants.
REQ-032 The count register SHALL be a sub-module, count_core: WIDTH-parameterised, with inputs clk, reset, clr and en and output q, where clr has priority over en.
REQ-033 The FSM, prescaler and terminal compare SHALL reside in timer_sequencer.

Verification
REQ-034 One-shot, P=0, load_val=3, start at cycle 0 -> o_count steps 1, 2, 3 at cycles 1-3; tick=1 and o_count=0 at cycle 4; done=1 from cycle 4.
REQ-035 Periodic, P=1, load_val=2 -> tick at cycles 6, 12, 18; busy stays 1 throughout.
REQ-036 Stop in the same cycle as a terminal event (one-shot, P=0, load_val=1, stop at cycle 2) -> no tick, state IDLE, o_count=1, done=0.
REQ-037 Restart in RUN: start with load_val=5, then start with load_val=1 at cycle 3 -> o_count=0 at cycle 3, and the first tick at cycle 5.
REQ-038 Reset at cycle 2 of a periodic run with load_val=255, P=15 -> all outputs 0 at cycle 3, and no tick for the next 20 cycles.
REQ-039 Full range, WIDTH=8, load_val=255, P=0, one-shot -> tick at cycle 256 with o_count wrapping 255 -> 0.
